interleaver_ctrl: RTL and testbench

Parametrised ping-pong controller for the turbo-interleaver datapath. It sequences two bit-RAM banks so that one bank fills from the CRC stage while the other drains into the permutation/read stage. It generates all bank addresses and write enables, plus block-level ready/done status. Block length is run-time (set by `in_end`) rather than a fixed two-size choice, and the read side is flow-controlled.

---
 rtl/interleaver_pkg.sv | 30 +++
 rtl/bank_counter.sv | 36 +++
 rtl/interleaver_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_interleaver_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// Shared types and helpers for the turbo-interleaver ping-pong controller.
//   BANKS      : number of bit-RAM banks (ping-pong pair)
//   wr_state_e : fill-side FSM states
//   rd_state_e : drain-side FSM states
//   clog2      : ceil(log2(value)), used for elaboration-time parameter checks
package interleaver_pkg;

  localparam int unsigned BANKS = 2;

  typedef enum logic [1:0] {
    WIdle,
    WFill,
    WDrop
  } wr_state_e;

  typedef enum logic {
    RIdle,
    RDrain
  } rd_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/bank_counter.sv
// Address counter for one side (fill or drain) of the ping-pong banks.
//   clk, reset : clock, asynchronous active-high reset
//   en         : count up by one
//   clr        : synchronous clear; with en also set, the counter restarts at 1
//                (the cleared position is consumed in the same cycle)
//   term       : terminal value to compare against
//   count      : current count
//   at_term    : count == term
module bank_counter #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = clr ? '0 : count_q;
    if (en) count_d = count_d + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/interleaver_ctrl.sv
// Ping-pong controller for the turbo-interleaver bit RAMs: one bank fills from the
// CRC stage while the other drains to the permutation stage.
//   clk, reset          : clock, asynchronous active-high reset
//   in_start/valid/end  : input bit framing; in_ready back-pressures the source
//   wr_addr, ram_we     : fill address and one-hot bank write enable (same cycle as bit)
//   rd_addr, rd_bank    : linear drain index and bank; rd_en strobes the RAMs
//   out_ready           : early ready from downstream (gates rd_en)
//   out_valid, out_last : RAM data valid / last bit, one cycle after rd_en
//   blk_len             : length of the block being drained
//   done, err_len       : end-of-block pulse, bad-length pulse
module interleaver_ctrl
  import interleaver_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned MAX_LEN = 6144,
  parameter int unsigned MIN_LEN = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic              in_valid,
  input  logic              in_end,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        ram_we,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              rd_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [ADDR_W:0]   blk_len,
  output logic              done,
  output logic              err_len
);

  // One extra bit so MAX_LEN == 2**ADDR_W is representable.
  localparam int unsigned CW = ADDR_W + 1;

  if (clog2(MAX_LEN) > ADDR_W || MIN_LEN < 1 || MIN_LEN > MAX_LEN) begin : g_bad_params
    $error("interleaver_ctrl: illegal ADDR_W/MAX_LEN/MIN_LEN combination");
  end

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [BANKS-1:0]         full_q, full_d;
  logic [BANKS-1:0][CW-1:0] len_q, len_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [CW-1:0]            blk_len_q, blk_len_d;
  logic                     out_valid_q, out_last_q, done_q;

  // Fill-side signals
  logic          accept, blk_start, in_blk, overlong, short_blk, wr_close;
  logic          wr_cnt_en, wr_cnt_clr, wr_at_term;
  logic [CW-1:0] wr_count, base, end_len, close_len;

  // Drain-side signals
  logic          rd_cnt_en, rd_cnt_clr, rd_at_term, rd_release, rd_last;
  logic [CW-1:0] rd_count;
  logic          unused_rd_msb;

  bank_counter #(
    .W (CW)
  ) u_wr_counter (
    .clk     (clk),
    .reset   (reset),
    .en      (wr_cnt_en),
    .clr     (wr_cnt_clr),
    .term    (CW'(MAX_LEN - 1)),
    .count   (wr_count),
    .at_term (wr_at_term)
  );

  bank_counter #(
    .W (CW)
  ) u_rd_counter (
    .clk     (clk),
    .reset   (reset),
    .en      (rd_cnt_en),
    .clr     (rd_cnt_clr),
    .term    (blk_len_q - CW'(1)),
    .count   (rd_count),
    .at_term (rd_at_term)
  );

  // ---------------------------------------------------------------------------
  // Fill side
  // ---------------------------------------------------------------------------
  assign in_ready = (wr_state_q != WIdle) | ~full_q[wr_bank_q];
  assign accept   = in_valid & in_ready;

  // A start outside W_DROP always (re)opens a block at address 0.
  assign blk_start = accept & in_start & (wr_state_q != WDrop);
  assign in_blk    = blk_start | (accept & (wr_state_q == WFill));
  assign base      = blk_start ? '0 : wr_count;
  assign end_len   = base + CW'(1);

  // The bit at MAX_LEN-1 without in_end means the block cannot end legally.
  assign overlong  = in_blk & ~in_end & (blk_start ? (MAX_LEN == 1) : wr_at_term);
  assign short_blk = in_blk & in_end & (end_len < CW'(MIN_LEN));
  assign wr_close  = (in_blk & in_end & ~short_blk) | overlong;
  assign close_len = overlong ? CW'(MAX_LEN) : end_len;

  assign wr_addr = base[ADDR_W-1:0];
  assign err_len = (blk_start & (wr_state_q == WFill)) | short_blk | overlong;

  always_comb begin
    ram_we = '0;
    if (in_blk) ram_we[wr_bank_q] = 1'b1;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_cnt_en  = 1'b0;
    wr_cnt_clr = 1'b0;
    if (in_blk) begin
      if (in_end) begin
        wr_state_d = WIdle;
        wr_cnt_clr = 1'b1;
        if (!short_blk) wr_bank_d = ~wr_bank_q;
      end else if (overlong) begin
        wr_state_d = WDrop;
        wr_cnt_clr = 1'b1;
        wr_bank_d  = ~wr_bank_q;
      end else begin
        wr_state_d = WFill;
        wr_cnt_clr = blk_start;
        wr_cnt_en  = 1'b1;
      end
    end else if (wr_state_q == WDrop && accept && in_end) begin
      wr_state_d = WIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain side
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    blk_len_d  = blk_len_q;
    rd_cnt_en  = 1'b0;
    rd_cnt_clr = 1'b0;
    rd_en      = 1'b0;
    rd_release = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RDrain;
          blk_len_d  = len_q[rd_bank_q];
          rd_cnt_clr = 1'b1;
        end
      end
      RDrain: begin
        rd_en = out_ready;
        if (out_ready) begin
          if (rd_at_term) begin
            rd_release = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_state_d = RIdle;
            rd_cnt_clr = 1'b1;
          end else begin
            rd_cnt_en = 1'b1;
          end
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  assign rd_last       = rd_en & rd_at_term;
  assign rd_addr       = rd_count[ADDR_W-1:0];
  assign unused_rd_msb = rd_count[CW-1];

  // Close and release always target different banks, so both may apply at once.
  always_comb begin
    full_d = full_q;
    len_d  = len_q;
    if (wr_close) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = close_len;
    end
    if (rd_release) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q  <= WIdle;
      rd_state_q  <= RIdle;
      full_q      <= '0;
      len_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      blk_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      full_q      <= full_d;
      len_q       <= len_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      blk_len_q   <= blk_len_d;
      out_valid_q <= rd_en;
      out_last_q  <= rd_last;
      done_q      <= rd_last;
    end
  end

  assign rd_bank   = rd_bank_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign blk_len   = blk_len_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed-vector bench for interleaver_ctrl (ADDR_W=13, MAX_LEN=6144, MIN_LEN=40).
module tb_interleaver_ctrl;

  localparam int unsigned ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_start = 1'b0, in_valid = 1'b0, in_end = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [1:0]        ram_we;
  logic              rd_bank, rd_en;
  logic              out_ready = 1'b0;
  logic              out_valid, out_last, done, err_len;
  logic [ADDR_W:0]   blk_len;

  interleaver_ctrl #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (6144),
    .MIN_LEN (40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_start  (in_start),
    .in_valid  (in_valid),
    .in_end    (in_end),
    .in_ready  (in_ready),
    .wr_addr   (wr_addr),
    .ram_we    (ram_we),
    .rd_addr   (rd_addr),
    .rd_bank   (rd_bank),
    .rd_en     (rd_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .blk_len   (blk_len),
    .done      (done),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge; inputs change 1ns after the rising edge.
  logic       mon_clr = 1'b0;
  logic [1:0] exp_we = 2'b00;
  int         exp_addr = 0;
  int we_bad, we_n0, we_n1, rdy_low, rd_n0, rd_n1, rd_bad, rd_seq, first_rd;
  int done_n, done_cyc, done_len, last_n, err_n, err_cyc;
  logic       last_bank;
  logic [7:0] done_banks;

  always @(negedge clk) begin
    if (mon_clr) begin
      we_bad <= 0; we_n0 <= 0; we_n1 <= 0; rdy_low <= 0; rd_n0 <= 0; rd_n1 <= 0;
      rd_bad <= 0; rd_seq <= 0; first_rd <= -1; done_n <= 0; done_cyc <= -1;
      done_len <= 0; last_n <= 0; err_n <= 0; err_cyc <= -1; last_bank <= 1'b0;
      done_banks <= '0;
    end else begin
      if (ram_we !== exp_we || (exp_we != 2'b00 && wr_addr !== exp_addr[ADDR_W-1:0]))
        we_bad <= we_bad + 1;
      if (ram_we[0]) we_n0 <= we_n0 + 1;
      if (ram_we[1]) we_n1 <= we_n1 + 1;
      if (!in_ready) rdy_low <= rdy_low + 1;
      if (rd_en) begin
        if (rd_bank) rd_n1 <= rd_n1 + 1;
        else         rd_n0 <= rd_n0 + 1;
        if (first_rd < 0) first_rd <= cyc;
        if (rd_addr !== rd_seq[ADDR_W-1:0]) rd_bad <= rd_bad + 1;
        rd_seq    <= rd_seq + 1;
        last_bank <= rd_bank;
      end
      if (done) begin
        done_n     <= done_n + 1;
        done_cyc   <= cyc;
        done_len   <= int'(blk_len);
        done_banks <= {done_banks[6:0], last_bank};
        rd_seq     <= 0;
      end
      if (out_last && out_valid) last_n <= last_n + 1;
      if (err_len) begin
        err_n <= err_n + 1;
        if (err_cyc < 0) err_cyc <= cyc;
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic [1:0] we,
                       input int addr);
    @(posedge clk);
    #1;
    in_valid = v; in_start = s; in_end = e; exp_we = we; exp_addr = addr;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'b00, 0);
  endtask

  task automatic send_block(input logic bank, input int len);
    for (int i = 0; i < len; i++)
      drive(1'b1, i == 0, i == len - 1, bank ? 2'b10 : 2'b01, i);
  endtask

  task automatic mon_reset();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    idle_cyc(1);
    while (done_n < n && k < budget) begin
      idle_cyc(1);
      k++;
    end
    check_eq(tag, done_n, n);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_flags"}, {23'd0, in_ready, ram_we, rd_bank, rd_en, out_valid, out_last,
                               done, err_len}, 32'h100);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check_eq({tag, "_blk_len"}, 32'(blk_len), 0);
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is visible before the next edge.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; exp_we = 2'b00;
    #1 check_reset(tag);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int end_cyc, mark_cyc, rdy_snap;

  initial begin
    // Reset values
    apply_reset("rst");

    // 1: single 40-bit block, out_ready=1
    mon_reset();
    out_ready = 1'b1;
    send_block(1'b0, 40);
    end_cyc = cyc;
    wait_done("t1_done", 1, 100);
    check_eq("t1_we_bad", we_bad, 0);
    check_eq("t1_we0", we_n0, 40);
    check_eq("t1_first_rd_lat", first_rd - end_cyc, 2);
    check_eq("t1_done_lat", done_cyc - first_rd, 40);
    check_eq("t1_blk_len", done_len, 40);
    check_eq("t1_rd0", rd_n0, 40);
    check_eq("t1_rd_addr_bad", rd_bad, 0);
    check_eq("t1_last", last_n, 1);
    check_eq("t1_err", err_n, 0);

    // 2: back-to-back 6144 + 1056
    apply_reset("rst2");
    mon_reset();
    out_ready = 1'b1;
    send_block(1'b0, 6144);
    send_block(1'b1, 1056);
    rdy_snap = rdy_low;
    wait_done("t2_done", 2, 8000);
    check_eq("t2_rdy_low", rdy_snap, 0);
    check_eq("t2_we_bad", we_bad, 0);
    check_eq("t2_we0", we_n0, 6144);
    check_eq("t2_we1", we_n1, 1056);
    check_eq("t2_rd0", rd_n0, 6144);
    check_eq("t2_rd1", rd_n1, 1056);
    check_eq("t2_order", 32'(done_banks[1:0]), 32'b01);
    check_eq("t2_blk_len", done_len, 1056);

    // 3: three blocks with out_ready=0 until the third stalls
    apply_reset("rst3");
    mon_reset();
    out_ready = 1'b0;
    send_block(1'b0, 40);
    send_block(1'b1, 40);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 0);
    idle_cyc(1);
    check_eq("t3_stall_rdy_low", rdy_low, 8);
    check_eq("t3_no_done", done_n, 0);
    out_ready = 1'b1;
    wait_done("t3_done_b0", 1, 100);
    check_eq("t3_in_ready_up", 32'(in_ready), 1);
    send_block(1'b0, 40);
    wait_done("t3_done_all", 3, 300);
    check_eq("t3_we_bad", we_bad, 0);
    check_eq("t3_rd0", rd_n0, 80);
    check_eq("t3_rd1", rd_n1, 40);
    check_eq("t3_order", 32'(done_banks[2:0]), 32'b010);

    // 4: 6200 bits, no in_end before bit 6200
    apply_reset("rst4");
    mon_reset();
    out_ready = 1'b1;
    mark_cyc = 0;
    for (int i = 0; i < 6200; i++) begin
      drive(1'b1, i == 0, i == 6199, (i < 6144) ? 2'b01 : 2'b00, i);
      if (i == 6143) mark_cyc = cyc;
    end
    wait_done("t4_done", 1, 8000);
    check_eq("t4_err_n", err_n, 1);
    check_eq("t4_err_cyc", err_cyc, mark_cyc);
    check_eq("t4_we_bad", we_bad, 0);
    check_eq("t4_we0", we_n0, 6144);
    check_eq("t4_blk_len", done_len, 6144);
    check_eq("t4_rd0", rd_n0, 6144);

    // 5: in_start at bit 20 restarts the block
    apply_reset("rst5");
    mon_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 1'b0, 2'b01, i);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 0);
    mark_cyc = cyc;
    for (int i = 1; i < 40; i++) drive(1'b1, 1'b0, i == 39, 2'b01, i);
    wait_done("t5_done", 1, 100);
    idle_cyc(60);
    check_eq("t5_done_once", done_n, 1);
    check_eq("t5_err_n", err_n, 1);
    check_eq("t5_err_cyc", err_cyc, mark_cyc);
    check_eq("t5_we_bad", we_bad, 0);
    check_eq("t5_rd0", rd_n0, 40);
    check_eq("t5_blk_len", done_len, 40);

    // 6: short block (39 < MIN_LEN) is discarded; a 40-bit block then uses bank 0
    apply_reset("rst6");
    mon_reset();
    out_ready = 1'b1;
    send_block(1'b0, 39);
    end_cyc = cyc;
    idle_cyc(50);
    check_eq("t6_err_n", err_n, 1);
    check_eq("t6_err_cyc", err_cyc, end_cyc);
    check_eq("t6_no_drain", rd_n0 + rd_n1, 0);
    check_eq("t6_in_ready", 32'(in_ready), 1);
    send_block(1'b0, 40);
    wait_done("t6_done", 1, 100);
    check_eq("t6_we_bad", we_bad, 0);
    check_eq("t6_blk_len", done_len, 40);
    check_eq("t6_rd0", rd_n0, 40);

    // 7: reset mid-drain while out_ready toggles
    apply_reset("rst7");
    mon_reset();
    out_ready = 1'b0;
    send_block(1'b0, 40);
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'b00, 0);
      out_ready = ~out_ready;
    end
    apply_reset("t7_async");
    idle_cyc(60);
    check_eq("t7_no_done", done_n, 0);
    check_eq("t7_no_last", last_n, 0);
    check_eq("t7_in_ready", 32'(in_ready), 1);
    check_eq("t7_rd_en", 32'(rd_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
